pc_fetch_ctrl: RTL and testbench

- Program-counter register plus instruction-fetch sequencer that consumes D_OUT of the n-bit 2:1 PC-source mux (PC+4 vs. branch/jump target).
- Holds the current PC, drives a req/ack fetch handshake to instruction memory, flags when a fetched instruction is valid, and loads the mux output on PC_WRITE.
- Sits between the PC-source mux and the instruction memory in the OTTER datapath.

---
 rtl/pc_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: OTTER program counter plus instruction-fetch req/ack sequencer.
// Build option: define PC_MISALIGN_TRAP_EN to trap misaligned PC_WRITE targets into FLT.
module pc_fetch_ctrl #(
  parameter int unsigned    n        = 32,
  parameter logic [n-1:0]   RST_ADDR = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [n-1:0]  PC_DIN,
  input  logic          PC_WRITE,
  input  logic          IF_ACK,
  output logic [n-1:0]  PC_COUNT,
  output logic [n-1:0]  PC_PLUS4,
  output logic          IF_REQ,
  output logic [n-1:0]  IF_ADDR,
  output logic          INSTR_VALID,
  output logic [31:0]   RET_CNT,
  output logic          FAULT
);

  // state | meaning
  // IDLE  | just out of reset, first request issued next cycle
  // REQ   | fetch outstanding at PC_COUNT, waiting for IF_ACK
  // HOLD  | instruction valid for decode, waiting for PC_WRITE
  // FLT   | misaligned target trapped, frozen until RST
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    FLT  = 2'd3
  } state_t;

  state_t         state;
  logic [n-1:0]   pc;
  logic [31:0]    ret_cnt;
  logic           if_req;
  logic           instr_valid;
  logic [n-1:0]   pc_din_aligned;

  // Masking keeps every PC_DIN bit in use; in the trap build an accepted load is already aligned.
  assign pc_din_aligned = PC_DIN & {{(n-2){1'b1}}, 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  logic fault;
  logic misaligned;
  assign misaligned = |PC_DIN[1:0];
  assign FAULT      = fault;
`else
  assign FAULT      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      pc          <= RST_ADDR;
      ret_cnt     <= 32'd0;
      if_req      <= 1'b0;
      instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state  <= REQ;
          if_req <= 1'b1;
        end
        REQ: begin
          if (IF_ACK) begin
            state       <= HOLD;
            if_req      <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (PC_WRITE) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (misaligned) begin
              state       <= FLT;
              fault       <= 1'b1;
              instr_valid <= 1'b0;
            end else
`endif
            begin
              state       <= REQ;
              pc          <= pc_din_aligned;
              ret_cnt     <= ret_cnt + 32'd1;
              instr_valid <= 1'b0;
              if_req      <= 1'b1;
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign PC_COUNT    = pc;
  assign PC_PLUS4    = pc + n'(4);
  assign IF_ADDR     = pc;
  assign IF_REQ      = if_req;
  assign INSTR_VALID = instr_valid;
  assign RET_CNT     = ret_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan scenarios plus a randomized run
// compared cycle by cycle against a fetch-phase reference model.
module tb_pc_fetch_ctrl;
  localparam int unsigned  N  = 32;
  localparam logic [N-1:0] RA = '0;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  PC_DIN = '0;
  logic          PC_WRITE = 1'b0;
  logic          IF_ACK = 1'b0;
  logic [N-1:0]  PC_COUNT, PC_PLUS4, IF_ADDR;
  logic          IF_REQ, INSTR_VALID, FAULT;
  logic [31:0]   RET_CNT;

  pc_fetch_ctrl #(.n(N), .RST_ADDR(RA)) dut (
    .CLK(CLK), .RST(RST), .PC_DIN(PC_DIN), .PC_WRITE(PC_WRITE), .IF_ACK(IF_ACK),
    .PC_COUNT(PC_COUNT), .PC_PLUS4(PC_PLUS4), .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR),
    .INSTR_VALID(INSTR_VALID), .RET_CNT(RET_CNT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch phase tracked as flags (waiting-to-start, request out, instr held, trapped).
  logic [N-1:0] m_pc;
  logic [31:0]  m_ret;
  bit           m_idle, m_req, m_valid, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (RST) begin
      m_pc = RA; m_ret = 0; m_idle = 1; m_req = 0; m_valid = 0; m_fault = 0;
    end else if (m_fault) begin
      // trapped: nothing moves until reset
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (IF_ACK) begin m_req = 0; m_valid = 1; end
    end else if (m_valid && PC_WRITE) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (PC_DIN % 4 != 0) begin
        m_fault = 1; m_valid = 0;
      end else
`endif
      begin
        m_pc    = PC_DIN - (PC_DIN % 4);
        m_ret   = m_ret + 1;
        m_valid = 0;
        m_req   = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("pc_count",    PC_COUNT,    m_pc);
    chk("pc_plus4",    PC_PLUS4,    m_pc + 32'd4);
    chk("if_addr",     IF_ADDR,     m_pc);
    chk("if_req",      {31'd0, IF_REQ},      {31'd0, m_req});
    chk("instr_valid", {31'd0, INSTR_VALID}, {31'd0, m_valid});
    chk("ret_cnt",     RET_CNT,     m_ret);
    chk("fault",       {31'd0, FAULT},       {31'd0, m_fault});
  endtask

  task automatic step(input bit rst, input bit wr, input bit ack, input logic [N-1:0] din);
    RST = rst; PC_WRITE = wr; IF_ACK = ack; PC_DIN = din;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    // reset two cycles, then first fetch
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    chk("rst_if_req", {31'd0, IF_REQ}, 32'd0);
    chk("rst_pc", PC_COUNT, 32'h0);
    step(0, 0, 0, '0);
    chk("first_req", {31'd0, IF_REQ}, 32'd1);
    chk("first_addr", IF_ADDR, 32'h0);
    chk("first_plus4", PC_PLUS4, 32'h4);
    chk("first_ret", RET_CNT, 32'd0);

    // stall in REQ with PC_WRITE pulses that must be ignored
    for (int i = 0; i < 5; i++) step(0, i[0], 0, 32'h200);
    chk("stall_req", {31'd0, IF_REQ}, 32'd1);
    chk("stall_pc", PC_COUNT, 32'h0);
    step(0, 0, 1, '0);
    chk("ack_valid", {31'd0, INSTR_VALID}, 32'd1);
    chk("ack_req", {31'd0, IF_REQ}, 32'd0);

    // aligned load; held PC_WRITE must load once
    step(0, 1, 0, 32'h100);
    chk("load_pc", PC_COUNT, 32'h100);
    chk("load_ret", RET_CNT, 32'd1);
    chk("load_addr", IF_ADDR, 32'h100);
    step(0, 1, 0, 32'h300);
    chk("held_wr_pc", PC_COUNT, 32'h100);

    // PC_PLUS4 wrap
    step(0, 0, 1, '0);
    step(0, 1, 0, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);

    // RET_CNT wrap using a forced preload while holding
    step(0, 0, 1, '0);
    force dut.ret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ret_cnt;
    m_ret = 32'hFFFF_FFFF;
    #1;
    chk("ret_preload", RET_CNT, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'h100);
    chk("ret_wrap", RET_CNT, 32'd0);

    // misaligned target
    step(0, 0, 1, '0);
    step(0, 1, 0, 32'h102);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, FAULT}, 32'd1);
    chk("mis_pc", PC_COUNT, 32'h100);
    step(0, 1, 1, 32'h400);
    step(0, 1, 1, 32'h400);
    chk("mis_frozen_req", {31'd0, IF_REQ}, 32'd0);
    chk("mis_frozen_ret", RET_CNT, 32'd0);
`else
    chk("mis_pc", PC_COUNT, 32'h100);
    chk("mis_fault", {31'd0, FAULT}, 32'd0);
    chk("mis_ret", RET_CNT, 32'd1);
`endif

    // reset mid-REQ and mid-HOLD
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(1, 0, 1, '0);
    chk("rst_req_ifreq", {31'd0, IF_REQ}, 32'd0);
    chk("rst_req_pc", PC_COUNT, RA);
    step(0, 0, 0, '0);
    step(0, 0, 1, '0);
    step(0, 1, 0, 32'h80);
    step(0, 0, 1, '0);
    step(1, 1, 0, 32'h40);
    chk("rst_hold_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("rst_hold_ret", RET_CNT, 32'd0);
    chk("rst_hold_fault", {31'd0, FAULT}, 32'd0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] d;
      d = $urandom;
      if ($urandom_range(3) != 0) d[1:0] = 2'b00;
      step($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(9) < 4, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
